// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock threshold FIFO: depth checks,
// pointer-width derivation and sticky error-flag bit positions.
package sync_fifo_pkg;

   localparam int unsigned OVF = 0;
   localparam int unsigned UDF = 1;

   function automatic bit is_pow2(input int unsigned n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/sync_fifo_thresh_if.sv
// Request/status bundle between a producer/consumer and sync_fifo_thresh.
// The FIFO takes the slave side; the block driving requests takes master.
interface sync_fifo_thresh_if
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8,
   localparam int unsigned PTR_W     = ptr_w(DEPTH)
);
   logic                  W_INC;
   logic [DATA_WIDTH-1:0] WR_DATA;
   logic                  R_INC;
   logic [DATA_WIDTH-1:0] RD_DATA;
   logic                  RD_VALID;
   logic [PTR_W:0]        AF_LEVEL;
   logic [PTR_W:0]        AE_LEVEL;
   logic                  ERR_CLR;
   logic                  FULL;
   logic                  EMPTY;
   logic                  ALMOST_FULL;
   logic                  ALMOST_EMPTY;
   logic [PTR_W:0]        COUNT;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;

   modport master (
      output W_INC, WR_DATA, R_INC, AF_LEVEL, AE_LEVEL, ERR_CLR,
      input  RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
             COUNT, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  W_INC, WR_DATA, R_INC, AF_LEVEL, AE_LEVEL, ERR_CLR,
      output RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
             COUNT, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8,
   localparam int unsigned AW        = ptr_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and
// sticky error flags. Define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_thresh
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8,
   localparam int unsigned PTR_W     = ptr_w(DEPTH)
) (
   input logic               CLK,
   input logic               RST,
   sync_fifo_thresh_if.slave bus
);
   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_thresh: DEPTH must be a power of 2 and >= 2");
   end

   logic [PTR_W:0]        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PTR_W:0]        count_q, count_d;
   logic                  full_q, full_d, empty_q, empty_d;
   logic                  af_q, af_d, ae_q, ae_d;
   logic [1:0]            err_q, err_d;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Acceptance uses the registered flags, so a full FIFO still pops and an
   // empty FIFO still pushes when both requests arrive together.
   always_comb begin
      wr_acc  = bus.W_INC & ~full_q;
      rd_acc  = bus.R_INC & ~empty_q;
      wptr_d  = wptr_q + {{PTR_W{1'b0}}, wr_acc};
      rptr_d  = rptr_q + {{PTR_W{1'b0}}, rd_acc};
      count_d = wptr_d - rptr_d;
      full_d  = (wptr_d ^ rptr_d) == {1'b1, {PTR_W{1'b0}}};
      empty_d = (wptr_d == rptr_d);
      af_d    = (count_d >= bus.AF_LEVEL);
      ae_d    = (count_d <= bus.AE_LEVEL);
      err_d   = bus.ERR_CLR ? '0 : err_q;
      if (bus.W_INC && full_q)  err_d[OVF] = 1'b1;
      if (bus.R_INC && empty_q) err_d[UDF] = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         err_q   <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         af_q    <= af_d;
         ae_q    <= ae_d;
         err_q   <= err_d;
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) u_mem (
      .clk  (CLK),
      .we   (wr_acc & ~RST),
      .waddr(wptr_q[PTR_W-1:0]),
      .wdata(bus.WR_DATA),
      .raddr(rptr_q[PTR_W-1:0]),
      .rdata(mem_rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign bus.RD_DATA  = mem_rdata;
   assign bus.RD_VALID = ~empty_q;
`else
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;

   always_comb begin
      rd_data_d  = rd_acc ? mem_rdata : rd_data_q;
      rd_valid_d = rd_acc;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign bus.RD_DATA  = rd_data_q;
   assign bus.RD_VALID = rd_valid_q;
`endif

   assign bus.COUNT        = count_q;
   assign bus.FULL         = full_q;
   assign bus.EMPTY        = empty_q;
   assign bus.ALMOST_FULL  = af_q;
   assign bus.ALMOST_EMPTY = ae_q;
   assign bus.OVERFLOW     = err_q[OVF];
   assign bus.UNDERFLOW    = err_q[UDF];
endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Scoreboard bench for sync_fifo_thresh (DEPTH=8, DATA_WIDTH=8); follows
// SYNC_FIFO_FWFT_EN when the macro is defined for the build.
module tb_sync_fifo_thresh;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   sync_fifo_thresh_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   sync_fifo_thresh #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] sb [$];
   int         m_cnt;
   logic       m_af, m_ae, m_ovf, m_udf;
   logic [7:0] m_rd;
   logic [3:0] af_lvl, ae_lvl;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, ".count"}, 32'(bus.COUNT), 32'(m_cnt));
      check({tag, ".full"},  bus.FULL,  m_cnt == DEPTH);
      check({tag, ".empty"}, bus.EMPTY, m_cnt == 0);
      check({tag, ".af"},    bus.ALMOST_FULL,  m_af);
      check({tag, ".ae"},    bus.ALMOST_EMPTY, m_ae);
      check({tag, ".ovf"},   bus.OVERFLOW,  m_ovf);
      check({tag, ".udf"},   bus.UNDERFLOW, m_udf);
   endtask

   task automatic step(input string tag, input logic w, input logic [7:0] d,
                       input logic r, input logic clr);
      bit wa, ra;
      @(negedge CLK);
      bus.W_INC    = w;
      bus.WR_DATA  = d;
      bus.R_INC    = r;
      bus.ERR_CLR  = clr;
      bus.AF_LEVEL = af_lvl;
      bus.AE_LEVEL = ae_lvl;
      wa = w && (m_cnt < DEPTH);
      ra = r && (m_cnt > 0);
      @(posedge CLK);
      #1;
      if (clr) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_udf = 1'b1;
      m_cnt = m_cnt + int'(wa) - int'(ra);
      m_af  = m_cnt >= int'(af_lvl);
      m_ae  = m_cnt <= int'(ae_lvl);
`ifdef SYNC_FIFO_FWFT_EN
      if (ra) void'(sb.pop_front());
      if (wa) sb.push_back(d);
      check({tag, ".rd_valid"}, bus.RD_VALID, sb.size() != 0);
      if (sb.size() != 0) check({tag, ".rd_data"}, bus.RD_DATA, sb[0]);
`else
      check({tag, ".rd_valid"}, bus.RD_VALID, ra);
      if (bus.RD_VALID && sb.size() != 0) m_rd = sb.pop_front();
      if (wa) sb.push_back(d);
      check({tag, ".rd_data"}, bus.RD_DATA, m_rd);
`endif
      check_status(tag);
   endtask

   task automatic do_reset(input string tag, input logic r);
      @(negedge CLK);
      RST         = 1'b1;
      bus.R_INC   = r;
      bus.W_INC   = 1'b0;
      bus.ERR_CLR = 1'b0;
      @(posedge CLK);
      #1;
      sb.delete();
      m_cnt = 0;
      m_af  = 1'b0;
      m_ae  = 1'b1;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rd  = '0;
      check_status(tag);
      check({tag, ".rd_valid"}, bus.RD_VALID, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      check({tag, ".rd_data"}, bus.RD_DATA, 8'h00);
`endif
      @(negedge CLK);
      RST       = 1'b0;
      bus.R_INC = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST          = 1'b1;
      bus.W_INC    = 1'b0;
      bus.WR_DATA  = '0;
      bus.R_INC    = 1'b0;
      bus.ERR_CLR  = 1'b0;
      af_lvl       = 4'd6;
      ae_lvl       = 4'd1;
      bus.AF_LEVEL = af_lvl;
      bus.AE_LEVEL = ae_lvl;
      do_reset("reset", 1'b0);

      // Fill: ALMOST_FULL on 6th edge, FULL on 8th, 9th write overflows.
      for (int i = 0; i < 8; i++) step("fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      step("overflow", 1'b1, 8'h99, 1'b0, 1'b0);
      step("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1);

      for (int i = 0; i < 8; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
      step("underflow", 1'b0, 8'h00, 1'b1, 1'b0);
      step("clr_udf", 1'b0, 8'h00, 1'b0, 1'b1);

      // Simultaneous read+write at COUNT=3, FULL and EMPTY.
      for (int i = 0; i < 3; i++) step("pre3", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      step("rw_at3", 1'b1, 8'h23, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step("tofull", 1'b1, 8'(8'h24 + i), 1'b0, 1'b0);
      step("rw_full", 1'b1, 8'hEE, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
      step("rw_empty", 1'b1, 8'h30, 1'b1, 1'b0);
      step("clr_both", 1'b0, 8'h00, 1'b1, 1'b1);

      // Wrap-around with interleaved pairs and steady-state overlap.
      for (int i = 0; i < 20; i++) begin
         step("wrap_w", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
         step("wrap_r", 1'b0, 8'h00, 1'b1, 1'b0);
      end
      step("ovl_pre", 1'b1, 8'h40, 1'b0, 1'b0);
      step("ovl_pre", 1'b1, 8'h41, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step("ovl_rw", 1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
      step("ovl_drain", 1'b0, 8'h00, 1'b1, 1'b0);
      step("ovl_drain", 1'b0, 8'h00, 1'b1, 1'b0);

      // Reset at COUNT=5 with R_INC high and OVERFLOW set.
      for (int i = 0; i < 8; i++) step("mid_fill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      step("mid_ovf", 1'b1, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("mid_rd", 1'b0, 8'h00, 1'b1, 1'b0);
      do_reset("mid_reset", 1'b1);

      // Single word: visible before any pop in FWFT, then one pop empties.
      step("single_w", 1'b1, 8'hA5, 1'b0, 1'b0);
      step("single_r", 1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic with moving thresholds.
      for (int i = 0; i < 300; i++) begin
         af_lvl = 4'($urandom_range(0, DEPTH));
         ae_lvl = 4'($urandom_range(0, DEPTH));
         step("rand", 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
